// File: rtl/descriptor_ring.sv
// Circular descriptor queue with registered show-ahead head, occupancy count and flush.
// Optional per-entry even parity enabled by defining DESC_RING_PARITY_EN.
module descriptor_ring #(
  parameter int NUM_DESC = 16,
  parameter int ADDR_W   = 16,
  parameter int PTR_W    = 32,
  localparam int DESC_W  = 2*ADDR_W + PTR_W,
  localparam int CW      = $clog2(NUM_DESC+1),
  localparam int IW      = $clog2(NUM_DESC)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              flush_i,
  input  logic              post_valid_i,
  output logic              post_ready_o,
  input  logic [DESC_W-1:0] post_data_i,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] src_address_o,
  output logic [ADDR_W-1:0] dst_address_o,
  output logic [PTR_W-1:0]  payload_ptr_o,
  output logic [CW-1:0]     count_o,
  output logic [IW-1:0]     wr_idx_o,
  output logic [IW-1:0]     rd_idx_o,
  output logic              parity_err_o
);

  typedef enum logic {ST_EMPTY, ST_VALID} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic              post_ready_q, post_ready_d;
  logic [DESC_W-1:0] data_q, data_d;
  logic [DESC_W-1:0] mem_q [NUM_DESC];
  logic              push, pop;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_DESC-1)) ? '0 : i + IW'(1);
  endfunction

  // Flush overrides both handshakes in the same cycle.
  always_comb begin
    push = post_valid_i && post_ready_q && !flush_i;
    pop  = fetch_valid_o && fetch_ready_i && !flush_i;
  end

  always_comb begin
    wr_idx_d     = push ? inc(wr_idx_q) : wr_idx_q;
    rd_idx_d     = pop ? inc(rd_idx_q) : rd_idx_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    post_ready_d = (count_d != CW'(NUM_DESC));
    data_d       = data_q;
    // Head register reloads on a pop or while empty; bypass when the new head is being posted now.
    if (pop || state_q == ST_EMPTY) begin
      if (push && count_q == CW'(pop)) data_d = post_data_i;
      else if (pop)                    data_d = mem_q[rd_idx_d];
    end
    if (flush_i) begin
      wr_idx_d     = '0;
      rd_idx_d     = '0;
      count_d      = '0;
      post_ready_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_VALID;
      ST_VALID: if (pop && count_q == CW'(1) && !push) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_comb begin
    fetch_valid_o = (state_q == ST_VALID);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= ST_EMPTY;
      count_q      <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      post_ready_q <= 1'b1;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      post_ready_q <= post_ready_d;
      data_q       <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_idx_q] <= post_data_i;
  end

`ifdef DESC_RING_PARITY_EN
  logic par_q [NUM_DESC];
  logic err_q, err_d;

  // Parity is checked on the stored copy of the entry being popped, not on the head register.
  always_comb begin
    err_d = err_q | (pop && ((^mem_q[rd_idx_q]) != par_q[rd_idx_q]));
    if (flush_i) err_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (push) par_q[wr_idx_q] <= ^post_data_i;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign parity_err_o = err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign post_ready_o  = post_ready_q;
  assign count_o       = count_q;
  assign wr_idx_o      = wr_idx_q;
  assign rd_idx_o      = rd_idx_q;
  assign src_address_o = data_q[DESC_W-1 -: ADDR_W];
  assign dst_address_o = data_q[PTR_W +: ADDR_W];
  assign payload_ptr_o = data_q[PTR_W-1:0];

endmodule

// File: tb/tb_descriptor_ring.sv
// Directed bench for descriptor_ring (NUM_DESC=4): reset, fill/wrap, simultaneous
// post/fetch, back-pressure, flush, parity and asynchronous reset.
module tb_descriptor_ring;
  localparam int N = 4, AW = 16, PW = 32, DW = 2*AW + PW, CW = 3, IW = 2;

  logic          clk = 1'b0, resetn = 1'b0, flush = 1'b0;
  logic          post_valid = 1'b0, fetch_ready = 1'b0;
  logic [DW-1:0] post_data = '0;
  logic          post_ready, fetch_valid, perr;
  logic [AW-1:0] src, dst;
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] wr_idx, rd_idx;
  int checks = 0, failures = 0;

  descriptor_ring #(.NUM_DESC(N), .ADDR_W(AW), .PTR_W(PW)) dut (
    .clk_i(clk), .resetn_i(resetn), .flush_i(flush),
    .post_valid_i(post_valid), .post_ready_o(post_ready), .post_data_i(post_data),
    .fetch_valid_o(fetch_valid), .fetch_ready_i(fetch_ready),
    .src_address_o(src), .dst_address_o(dst), .payload_ptr_o(ptr),
    .count_o(count), .wr_idx_o(wr_idx), .rd_idx_o(rd_idx), .parity_err_o(perr)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int i);
    return {16'h1000 + 16'(i), 16'h2000 + 16'(i), 32'hA000_0000 + 32'(i)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic post(input int i);
    post_valid = 1'b1; post_data = mk(i);
    step();
    post_valid = 1'b0;
  endtask

  task automatic chk_head(input string tag, input int i, input int cnt);
    chk({tag, ".valid"}, 64'(fetch_valid), 64'(1));
    chk({tag, ".src"},   64'(src), 64'(16'h1000 + 16'(i)));
    chk({tag, ".dst"},   64'(dst), 64'(16'h2000 + 16'(i)));
    chk({tag, ".ptr"},   64'(ptr), 64'(32'hA000_0000 + 32'(i)));
    chk({tag, ".count"}, 64'(count), 64'(cnt));
  endtask

  initial begin
    // 1: reset values and single post into empty ring
    step(); step();
    chk("rst.count", 64'(count), 0);
    chk("rst.wr", 64'(wr_idx), 0);
    chk("rst.rd", 64'(rd_idx), 0);
    chk("rst.fv", 64'(fetch_valid), 0);
    chk("rst.pr", 64'(post_ready), 1);
    chk("rst.perr", 64'(perr), 0);
    chk("rst.data", {src, dst, ptr}, 64'h0);
    resetn = 1'b1;
    step();
    post_valid = 1'b1; post_data = {16'h1111, 16'h2222, 32'h0000_AAAA};
    step();
    post_valid = 1'b0;
    chk("p1.fv", 64'(fetch_valid), 1);
    chk("p1.src", 64'(src), 64'h1111);
    chk("p1.dst", 64'(dst), 64'h2222);
    chk("p1.ptr", 64'(ptr), 64'hAAAA);
    chk("p1.count", 64'(count), 1);
    chk("p1.wr", 64'(wr_idx), 1);
    fetch_ready = 1'b1; step(); fetch_ready = 1'b0;
    chk("p1pop.fv", 64'(fetch_valid), 0);
    chk("p1pop.count", 64'(count), 0);
    chk("p1pop.rd", 64'(rd_idx), 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl0.wr", 64'(wr_idx), 0);
    chk("fl0.rd", 64'(rd_idx), 0);

    // 2: fill to full, held-off 5th post, pop 2, post 2 across the wrap
    post(0); chk_head("fill0", 0, 1);
    post(1); post(2);
    chk("fill.wr3", 64'(wr_idx), 3);
    post(3);
    chk("fill.wr0", 64'(wr_idx), 0);
    chk_head("full", 0, 4);
    chk("full.pr", 64'(post_ready), 0);
    post(9);
    chk("hold.count", 64'(count), 4);
    chk("hold.wr", 64'(wr_idx), 0);
    chk_head("hold", 0, 4);
    fetch_ready = 1'b1;
    step(); chk_head("pop1", 1, 3); chk("pop1.rd", 64'(rd_idx), 1);
    step(); chk_head("pop2", 2, 2); chk("pop2.rd", 64'(rd_idx), 2);
    fetch_ready = 1'b0;
    post(4); chk("wrap.wr1", 64'(wr_idx), 1);
    post(5); chk("wrap.wr2", 64'(wr_idx), 2);
    chk("wrap.count", 64'(count), 4);

    // 3: full with post+fetch pops only; then simultaneous post+fetch keeps count
    post_valid = 1'b1; post_data = mk(6); fetch_ready = 1'b1;
    step(); chk_head("fullsim", 3, 3); chk("fullsim.wr", 64'(wr_idx), 2);
    chk("fullsim.pr", 64'(post_ready), 1);
    step(); chk_head("sim3", 4, 3); chk("sim3.wr", 64'(wr_idx), 3);
    post_valid = 1'b0;
    step(); chk_head("pop5", 5, 2);
    post_valid = 1'b1; post_data = mk(7);
    step(); chk_head("sim2", 6, 2); chk("sim2.wr", 64'(wr_idx), 0);
    post_valid = 1'b0;
    step(); chk_head("pop7", 7, 1);
    step(); chk("drain.fv", 64'(fetch_valid), 0); chk("drain.count", 64'(count), 0);
    fetch_ready = 1'b0;

    // 4: back-pressure then full-rate drain
    post(10); post(11); post(12);
    for (int c = 0; c < 5; c++) chk_head($sformatf("bp%0d", c), 10, 3);
    fetch_ready = 1'b1;
    step(); chk_head("fr1", 11, 2);
    step(); chk_head("fr2", 12, 1);
    step(); chk("fr3.fv", 64'(fetch_valid), 0); chk("fr3.count", 64'(count), 0);
    fetch_ready = 1'b0;

    // 5: flush coinciding with a post
    post(13); post(14); post(15);
    chk("prefl.count", 64'(count), 3);
    flush = 1'b1; post_valid = 1'b1; post_data = mk(16);
    step();
    flush = 1'b0; post_valid = 1'b0;
    chk("fl.count", 64'(count), 0);
    chk("fl.fv", 64'(fetch_valid), 0);
    chk("fl.wr", 64'(wr_idx), 0);
    chk("fl.rd", 64'(rd_idx), 0);
    chk("fl.pr", 64'(post_ready), 1);
    step();
    chk("fl.discard", 64'(count), 0);
    post(17); chk_head("postfl", 17, 1);

    // 6: parity
`ifdef DESC_RING_PARITY_EN
    flush = 1'b1; step(); flush = 1'b0;
    post(18);
    dut.mem_q[0] = dut.mem_q[0] ^ 64'h1;
    chk("par.pre", 64'(perr), 0);
    fetch_ready = 1'b1; step(); fetch_ready = 1'b0;
    chk("par.set", 64'(perr), 1);
    step();
    chk("par.sticky", 64'(perr), 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("par.clr", 64'(perr), 0);
`else
    fetch_ready = 1'b1; step(); fetch_ready = 1'b0;
    chk("par.off", 64'(perr), 0);
`endif

    // asynchronous reset mid-operation
    post(20); post(21);
    chk("prerst.count", 64'(count), 2);
    #2 resetn = 1'b0; #1;
    chk("arst.count", 64'(count), 0);
    chk("arst.fv", 64'(fetch_valid), 0);
    chk("arst.wr", 64'(wr_idx), 0);
    chk("arst.pr", 64'(post_ready), 1);
    chk("arst.data", {src, dst, ptr}, 64'h0);
    step(); resetn = 1'b1; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
